// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the front-panel LED serialiser.
//
// Holds the register word indices, CTRL/STATUS bit positions, the
// shift FSM state encoding and a byte-strobe helper used by the
// register write path.
package fp_pkg;

    // Register word indices (byte address = index * 4)
    localparam int REG_CTRL   = 0;
    localparam int REG_STATUS = 1;
    localparam int REG_BRIGHT = 2;
    localparam int REG_LED0   = 3;

    // CTRL bit positions
    localparam int CTRL_AUTO   = 0;
    localparam int CTRL_START  = 1;
    localparam int CTRL_OE     = 2;
    localparam int CTRL_IRQ_EN = 3;

    // STATUS bit positions
    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_SHIFT_LOW  = 3'd2,
        ST_SHIFT_HIGH = 3'd3,
        ST_LATCH      = 3'd4
    } fp_state_e;

    // Expand a 4-bit AXI write strobe into a 32-bit byte-lane mask.
    function automatic logic [31:0] strb_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) begin
            m[8*i +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/axi_ifc.sv
// axi_ifc -- AXI4-Lite signal bundle (32-bit data).
//
// Parameter ADDR_W : byte address width.
// Modport slave    : used by register blocks.
// Modport master   : used by bus drivers.
interface axi_ifc #(
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_frontpanel_leds_timer.sv
// axi_frontpanel_leds_timer -- half-bit tick divider.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : counter advances only while high; held at zero otherwise
//   restart    : synchronously zeroes the counter (phase realignment)
//   tick       : one-cycle pulse every DIV cycles of running
module axi_frontpanel_leds_timer #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic restart,
    output logic tick
);
    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt;

    assign tick = run && !restart && (cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart || !run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/axi_frontpanel_leds.sv
// axi_frontpanel_leds -- AXI-Lite controlled serialiser for a chain of
// serial-in shift registers driving front-panel LEDs.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESETN : clock, asynchronous active-low reset
//   s                         : AXI-Lite slave (CTRL, STATUS, BRIGHTNESS, LED words)
//   INT_OUT                   : DONE & IRQ_EN
//   LED_CLOCK/LED_DATA        : serial clock/data, data MSB (highest LED) first
//   LED_LATCH                 : storage strobe, one half-bit after the last bit
//   LED_OE_N                  : active-low output enable
//   fsm_state                 : current shift FSM state (debug observation)
//
// Build option: define FP_LEDS_PWM_EN to add the BRIGHTNESS PWM on LED_OE_N.
// Without it BRIGHTNESS reads 0 and LED_OE_N = ~OE.
//
// Writes use the byte strobes; CTRL/STATUS/BRIGHTNESS only react to lane 0.
module axi_frontpanel_leds
    import fp_pkg::*;
#(
    parameter int C_S00_AXI_ACLK_FREQ_HZ = 100000000,
    parameter int C_S00_AXI_ADDR_WIDTH   = 5,
    parameter int SHIFT_FREQUENCY_HZ     = 1000000,
    parameter int LED_COUNT              = 64
) (
    input  logic      S_AXI_ACLK,
    input  logic      S_AXI_ARESETN,
    axi_ifc.slave     s,
    output logic      INT_OUT,
    output logic      LED_CLOCK,
    output logic      LED_DATA,
    output logic      LED_LATCH,
    output logic      LED_OE_N,
    output fp_state_e fsm_state
);
    localparam int WORDS        = LED_COUNT / 32;
    localparam int HALF_DIV_RAW = C_S00_AXI_ACLK_FREQ_HZ / (2 * SHIFT_FREQUENCY_HZ);
    localparam int HALF_DIV     = (HALF_DIV_RAW < 1) ? 1 : HALF_DIV_RAW;
    localparam int CNT_W        = $clog2(LED_COUNT);

    fp_state_e            state, state_next;
    logic [LED_COUNT-1:0] shadow, frame;
    logic [CNT_W-1:0]     bit_cnt;
    logic                 ctrl_auto, ctrl_oe, ctrl_irq_en, done;
    logic                 busy, tick, done_set, start_pulse;
    logic                 timer_run, timer_restart;
    logic                 wr_en, rd_en;
    int                   wr_word, rd_word;
    logic [31:0]          wmask, rd_value, bright_rd;
    logic                 unused_addr;

    // Handshake: a write is taken in the cycle where AWVALID and WVALID are
    // both high and no write response is pending (AWREADY=WREADY=that
    // condition); BVALID then stays high until BREADY. A read is taken when
    // ARVALID is high and no read data is pending; RVALID/RDATA hold until
    // RREADY. At most one transaction per channel is outstanding.
    assign wr_en     = s.awvalid & s.wvalid & ~s.bvalid;
    assign rd_en     = s.arvalid & ~s.rvalid;
    assign s.awready = wr_en;
    assign s.wready  = wr_en;
    assign s.arready = ~s.rvalid;
    assign s.bresp   = 2'b00;
    assign s.rresp   = 2'b00;

    assign wr_word     = int'(s.awaddr[C_S00_AXI_ADDR_WIDTH-1:2]);
    assign rd_word     = int'(s.araddr[C_S00_AXI_ADDR_WIDTH-1:2]);
    assign wmask       = strb_mask(s.wstrb);
    assign unused_addr = ^{s.awaddr[1:0], s.araddr[1:0]};

    // START is a pulse taken straight from the bus; it is only consulted in
    // IDLE, so a START during a frame is dropped rather than queued.
    assign start_pulse = wr_en && (wr_word == REG_CTRL) && s.wstrb[0] && s.wdata[CTRL_START];

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            s.bvalid <= 1'b0;
            s.rvalid <= 1'b0;
            s.rdata  <= '0;
        end else begin
            if (wr_en)         s.bvalid <= 1'b1;
            else if (s.bready) s.bvalid <= 1'b0;
            if (rd_en) begin
                s.rvalid <= 1'b1;
                s.rdata  <= rd_value;
            end else if (s.rready) begin
                s.rvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ctrl_auto   <= 1'b0;
            ctrl_oe     <= 1'b0;
            ctrl_irq_en <= 1'b0;
            done        <= 1'b0;
            shadow      <= '0;
        end else begin
            if (wr_en && (wr_word == REG_CTRL) && s.wstrb[0]) begin
                ctrl_auto   <= s.wdata[CTRL_AUTO];
                ctrl_oe     <= s.wdata[CTRL_OE];
                ctrl_irq_en <= s.wdata[CTRL_IRQ_EN];
            end
            // Frame completion beats a simultaneous write-1-to-clear.
            if (done_set) begin
                done <= 1'b1;
            end else if (wr_en && (wr_word == REG_STATUS) && s.wstrb[0] && s.wdata[STAT_DONE]) begin
                done <= 1'b0;
            end
            for (int k = 0; k < WORDS; k++) begin
                if (wr_en && (wr_word == REG_LED0 + k)) begin
                    shadow[32*k +: 32] <= (shadow[32*k +: 32] & ~wmask) | (s.wdata & wmask);
                end
            end
        end
    end

`ifdef FP_LEDS_PWM_EN
    logic [7:0] bright, pwm_cnt;

    // The divider free-runs so the PWM keeps cycling while idle; the FSM
    // only looks at ticks in its own states, and LOAD realigns the phase.
    assign timer_run = 1'b1;
    assign bright_rd = {24'b0, bright};
    assign LED_OE_N  = ~(ctrl_oe & (pwm_cnt < bright));

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            bright  <= 8'hFF;
            pwm_cnt <= 8'h00;
        end else begin
            if (wr_en && (wr_word == REG_BRIGHT) && s.wstrb[0]) bright <= s.wdata[7:0];
            if (tick) pwm_cnt <= pwm_cnt + 8'd1;
        end
    end
`else
    assign timer_run = busy;
    assign bright_rd = 32'b0;
    assign LED_OE_N  = ~ctrl_oe;
`endif

    always_comb begin
        rd_value = '0;
        if (rd_word == REG_CTRL) begin
            rd_value[CTRL_AUTO]   = ctrl_auto;
            rd_value[CTRL_OE]     = ctrl_oe;
            rd_value[CTRL_IRQ_EN] = ctrl_irq_en;
        end else if (rd_word == REG_STATUS) begin
            rd_value[STAT_BUSY] = busy;
            rd_value[STAT_DONE] = done;
        end else if (rd_word == REG_BRIGHT) begin
            rd_value = bright_rd;
        end else if ((rd_word >= REG_LED0) && (rd_word < REG_LED0 + WORDS)) begin
            rd_value = shadow[32*(rd_word - REG_LED0) +: 32];
        end
    end

    assign timer_restart = (state == ST_LOAD);

    axi_frontpanel_leds_timer #(
        .DIV(HALF_DIV)
    ) u_timer (
        .clk     (S_AXI_ACLK),
        .rst_n   (S_AXI_ARESETN),
        .run     (timer_run),
        .restart (timer_restart),
        .tick    (tick)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) state <= ST_IDLE;
        else                state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:       if (ctrl_auto || start_pulse) state_next = ST_LOAD;
            ST_LOAD:       state_next = ST_SHIFT_LOW;
            ST_SHIFT_LOW:  if (tick) state_next = ST_SHIFT_HIGH;
            ST_SHIFT_HIGH: if (tick) state_next = (bit_cnt == '0) ? ST_LATCH : ST_SHIFT_LOW;
            ST_LATCH:      if (tick) state_next = ST_IDLE;
            default:       state_next = ST_IDLE;
        endcase
    end

    // Frame and bit counter; the shift happens on the falling LED_CLOCK
    // transition so LED_DATA is stable across the whole high phase.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            frame   <= '0;
            bit_cnt <= '0;
        end else if (state == ST_LOAD) begin
            frame   <= shadow;
            bit_cnt <= CNT_W'(LED_COUNT - 1);
        end else if ((state == ST_SHIFT_HIGH) && tick) begin
            frame <= frame << 1;
            if (bit_cnt != '0) bit_cnt <= bit_cnt - CNT_W'(1);
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done_set  = (state == ST_LATCH) && tick;
    assign LED_CLOCK = (state == ST_SHIFT_HIGH);
    assign LED_DATA  = ((state == ST_SHIFT_LOW) || (state == ST_SHIFT_HIGH)) && frame[LED_COUNT-1];
    assign LED_LATCH = (state == ST_LATCH);
    assign INT_OUT   = done & ctrl_irq_en;
    assign fsm_state = state;
endmodule

// File: tb/tb_axi_frontpanel_leds.sv
// tb_axi_frontpanel_leds -- directed bench for axi_frontpanel_leds with
// LED_COUNT=32 and a 2-cycle half-bit divider. Frames seen on the serial
// pins are collected by a monitor and matched against expected frames
// queued when each frame is started. Define FP_LEDS_PWM_EN to also cover
// the brightness PWM build.
module tb_axi_frontpanel_leds;
    import fp_pkg::*;

    localparam logic [4:0] A_CTRL   = 5'h00;
    localparam logic [4:0] A_STATUS = 5'h04;
    localparam logic [4:0] A_BRIGHT = 5'h08;
    localparam logic [4:0] A_WORD0  = 5'h0C;
    localparam logic [4:0] A_WORD1  = 5'h10;
    localparam logic [4:0] A_TOP    = 5'h1C;

    logic      aclk = 1'b0;
    logic      aresetn;
    logic      int_out, led_clock, led_data, led_latch, led_oe_n;
    fp_state_e fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          rise_q[$];

    // monitor state
    logic [31:0] sh;
    int          cur_rises   = 0;
    int          latch_total = 0;
    logic        prev_clk    = 1'b0;
    logic        prev_latch  = 1'b0;

    axi_ifc #(.ADDR_W(5)) bus ();

    axi_frontpanel_leds #(
        .C_S00_AXI_ACLK_FREQ_HZ (4),
        .C_S00_AXI_ADDR_WIDTH   (5),
        .SHIFT_FREQUENCY_HZ     (1),
        .LED_COUNT              (32)
    ) dut (
        .S_AXI_ACLK    (aclk),
        .S_AXI_ARESETN (aresetn),
        .s             (bus),
        .INT_OUT       (int_out),
        .LED_CLOCK     (led_clock),
        .LED_DATA      (led_data),
        .LED_LATCH     (led_latch),
        .LED_OE_N      (led_oe_n),
        .fsm_state     (fsm_state)
    );

    // ---------------- clock / watchdog ----------------
    always #5 aclk = ~aclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- serial monitor ----------------
    always @(negedge aclk) begin
        if (!aresetn) begin
            sh         = '0;
            cur_rises  = 0;
            prev_clk   = 1'b0;
            prev_latch = 1'b0;
        end else begin
            if (led_clock && !prev_clk) begin
                sh = {sh[30:0], led_data};
                cur_rises++;
            end
            if (led_latch && !prev_latch) begin
                got_q.push_back(sh);
                rise_q.push_back(cur_rises);
                cur_rises = 0;
                latch_total++;
            end
            prev_clk   = led_clock;
            prev_latch = led_latch;
        end
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_frame(input string tag);
        int n;
        n = 0;
        while (got_q.size() == 0 && n < 2000) begin
            @(negedge aclk);
            n++;
        end
        check({tag, "_seen"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            check(tag, got_q.pop_front(), exp_q.pop_front());
            check({tag, "_rises"}, 32'(rise_q.pop_front()), 32'd32);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data);
        int n;
        n = 0;
        @(negedge aclk);
        bus.awaddr  = addr;
        bus.wdata   = data;
        bus.wstrb   = 4'hF;
        bus.awvalid = 1'b1;
        bus.wvalid  = 1'b1;
        #1;
        while (!bus.awready && n < 20) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (!bus.awready) check("wr_ready", {31'b0, bus.awready}, 32'd1);
        @(posedge aclk);
        #1;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int n;
        n = 0;
        @(negedge aclk);
        bus.araddr  = addr;
        bus.arvalid = 1'b1;
        #1;
        while (!bus.arready && n < 20) begin
            @(negedge aclk);
            #1;
            n++;
        end
        if (!bus.arready) check("rd_ready", {31'b0, bus.arready}, 32'd1);
        @(posedge aclk);
        #1;
        bus.arvalid = 1'b0;
        if (!bus.rvalid) check("rd_valid", {31'b0, bus.rvalid}, 32'd1);
        data = bus.rdata;
    endtask

    task automatic wait_latch_rise();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (!led_latch && n < 2000);
        check("latch_rise_seen", {31'b0, led_latch}, 32'd1);
    endtask

    task automatic wait_latch_fall();
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (led_latch && n < 2000);
    endtask

    task automatic wait_rises(input int target);
        int n;
        n = 0;
        do begin
            @(negedge aclk);
            n++;
        end while (cur_rises < target && n < 2000);
        check("rises_reached", 32'(cur_rises >= target), 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [31:0] rd;
        int          latch_before;
        int          low_cnt;

        aresetn     = 1'b0;
        bus.awaddr  = '0;
        bus.wdata   = '0;
        bus.wstrb   = '0;
        bus.awvalid = 1'b0;
        bus.wvalid  = 1'b0;
        bus.bready  = 1'b1;
        bus.araddr  = '0;
        bus.arvalid = 1'b0;
        bus.rready  = 1'b1;

        // reset values
        repeat (3) @(negedge aclk);
        check("rst_led_clock", {31'b0, led_clock}, 32'd0);
        check("rst_led_data",  {31'b0, led_data},  32'd0);
        check("rst_led_latch", {31'b0, led_latch}, 32'd0);
        check("rst_led_oe_n",  {31'b0, led_oe_n},  32'd1);
        check("rst_int_out",   {31'b0, int_out},   32'd0);
        check("rst_state",     32'(fsm_state),     32'(ST_IDLE));
        aresetn = 1'b1;

        axi_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
        axi_read(A_STATUS, rd); check("rst_status", rd, 32'h0);
        axi_read(A_WORD0, rd);  check("rst_word0", rd, 32'h0);
`ifdef FP_LEDS_PWM_EN
        axi_read(A_BRIGHT, rd); check("rst_bright", rd, 32'h0000_00FF);
`else
        axi_read(A_BRIGHT, rd); check("rst_bright", rd, 32'h0);
`endif

        // register map: shadow R/W, unmapped indices
        axi_write(A_WORD0, 32'hA500_0001);
        axi_read(A_WORD0, rd);  check("word0_rw", rd, 32'hA500_0001);
        axi_write(A_WORD1, 32'hDEAD_BEEF);
        axi_read(A_WORD1, rd);  check("unmapped_word1", rd, 32'h0);
        axi_read(A_TOP, rd);    check("unmapped_top", rd, 32'h0);
        axi_write(A_CTRL, 32'h0000_000C);
        axi_read(A_CTRL, rd);   check("ctrl_oe_irq", rd, 32'h0000_000C);
`ifndef FP_LEDS_PWM_EN
        check("oe_n_on", {31'b0, led_oe_n}, 32'd0);
`endif
        check("int_no_done", {31'b0, int_out}, 32'd0);
        axi_write(A_CTRL, 32'h0);
        check("oe_n_off", {31'b0, led_oe_n}, 32'd1);

        // single START frame
        axi_write(A_CTRL, 32'h2);
        exp_q.push_back(32'hA500_0001);
        axi_read(A_STATUS, rd); check("status_busy", rd, 32'h1);
        axi_read(A_CTRL, rd);   check("start_reads0", rd, 32'h0);
        check_frame("frame_a5");
        wait_latch_fall();
        axi_read(A_STATUS, rd); check("status_done", rd, 32'h2);
        check("int_masked", {31'b0, int_out}, 32'd0);
        axi_write(A_STATUS, 32'h2);
        axi_read(A_STATUS, rd); check("done_w1c", rd, 32'h0);

        // START while busy is dropped; W1C on the DONE-set cycle loses
        axi_write(A_WORD0, 32'h3C00_FF01);
        axi_write(A_CTRL, 32'h2);
        exp_q.push_back(32'h3C00_FF01);
        axi_write(A_CTRL, 32'h2);
        wait_latch_rise();
        axi_write(A_STATUS, 32'h2);
        check_frame("frame_busy_start");
        axi_read(A_STATUS, rd); check("done_set_wins", rd, 32'h2);
        repeat (300) @(negedge aclk);
        check("no_queued_start", 32'(got_q.size()), 32'd0);
        axi_write(A_STATUS, 32'h2);
        axi_read(A_STATUS, rd); check("done_clear2", rd, 32'h0);

        // AUTO + IRQ, mid-frame shadow rewrite, AUTO cleared mid-frame
        axi_write(A_WORD0, 32'h0);
        axi_write(A_CTRL, 32'h9);
        exp_q.push_back(32'h0);
        wait_rises(1);
        axi_write(A_WORD0, 32'hFFFF_FFFF);
        exp_q.push_back(32'hFFFF_FFFF);
        check_frame("auto_f1");
        wait_latch_fall();
        check("int_after_f1", {31'b0, int_out}, 32'd1);
        axi_write(A_STATUS, 32'h2);
        check("int_cleared", {31'b0, int_out}, 32'd0);
        axi_write(A_CTRL, 32'h8);
        check_frame("auto_f2");
        wait_latch_fall();
        check("int_after_f2", {31'b0, int_out}, 32'd1);
        repeat (300) @(negedge aclk);
        check("auto_stopped", 32'(got_q.size()), 32'd0);
        axi_read(A_STATUS, rd); check("auto_idle_status", rd, 32'h2);
        axi_write(A_STATUS, 32'h2);
        axi_write(A_CTRL, 32'h0);

        // reset mid-frame: abort without a latch pulse
        axi_write(A_WORD0, 32'hC3C3_C3C3);
        axi_write(A_CTRL, 32'h6);
`ifndef FP_LEDS_PWM_EN
        check("oe_n_frame", {31'b0, led_oe_n}, 32'd0);
`endif
        wait_rises(10);
        latch_before = latch_total;
        aresetn = 1'b0;
        #1;
        check("abort_led_clock", {31'b0, led_clock}, 32'd0);
        check("abort_led_data",  {31'b0, led_data},  32'd0);
        check("abort_led_latch", {31'b0, led_latch}, 32'd0);
        check("abort_led_oe_n",  {31'b0, led_oe_n},  32'd1);
        check("abort_int_out",   {31'b0, int_out},   32'd0);
        check("abort_state",     32'(fsm_state),     32'(ST_IDLE));
        repeat (4) @(negedge aclk);
        check("abort_no_latch", 32'(latch_total), 32'(latch_before));
        check("abort_no_frame", 32'(got_q.size()), 32'd0);
        aresetn = 1'b1;
        axi_read(A_CTRL, rd);  check("abort_ctrl", rd, 32'h0);
        axi_read(A_WORD0, rd); check("abort_word0", rd, 32'h0);
        axi_write(A_WORD0, 32'hC3C3_C3C3);
        axi_write(A_CTRL, 32'h2);
        exp_q.push_back(32'hC3C3_C3C3);
        check_frame("frame_restart");
        wait_latch_fall();
        axi_read(A_STATUS, rd); check("restart_done", rd, 32'h2);

        // brightness
`ifdef FP_LEDS_PWM_EN
        axi_write(A_CTRL, 32'h4);
        axi_write(A_BRIGHT, 32'h40);
        axi_read(A_BRIGHT, rd); check("bright_rw", rd, 32'h40);
        low_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge aclk);
            if (!led_oe_n) low_cnt++;
        end
        check("pwm_duty_40", 32'(low_cnt), 32'd128);
        axi_write(A_BRIGHT, 32'h0);
        low_cnt = 0;
        for (int i = 0; i < 512; i++) begin
            @(negedge aclk);
            if (!led_oe_n) low_cnt++;
        end
        check("pwm_duty_0", 32'(low_cnt), 32'd0);
        axi_write(A_CTRL, 32'h0);
`else
        low_cnt = 0;
        axi_write(A_BRIGHT, 32'h40);
        axi_read(A_BRIGHT, rd); check("bright_ignored", rd, 32'h0);
        check("bright_no_oe", {31'b0, led_oe_n} + 32'(low_cnt), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
